mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single system memory port between instruction fetch (port F) and the load/store unit (port L). It grants one requester at a time using round-robin, forwards the granted request to memory and routes the completion back. A watchdog aborts transactions that memory never completes. It sits between the fetch stage and LSU on one side and the memory interface on the other.

---
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares the single memory port between fetch (F) and the LSU (L).
// A watchdog aborts grants that memory never completes and flags them with err_o.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        f_valid_i,
  input  logic [31:0] f_addr_i,
  output logic        f_ready_o,
  input  logic        l_valid_i,
  input  logic [31:0] l_addr_i,
  input  logic [31:0] l_wdata_i,
  input  logic [3:0]  l_wstrb_i,
  output logic        l_ready_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [1:0]  grant_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrantF = 2'd1,
    StGrantL = 2'd2
  } state_e;

  // A zero timeout disables the watchdog entirely.
  localparam bit          WdogEn      = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      r_state;
  logic        r_last_l;
  logic [15:0] r_cnt;

  logic w_granted;
  logic w_timeout;
  logic w_done;

  assign w_granted = (r_state == StGrantF) || (r_state == StGrantL);
  assign w_timeout = WdogEn && w_granted && !mem_ready_i && (r_cnt == TimeoutLast);
  assign w_done    = w_granted && (mem_ready_i || w_timeout);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_last_l <= 1'b1;
      r_cnt    <= 16'd0;
    end else begin
      case (r_state)
        StIdle: begin
          // On a tie the port not granted last wins.
          if (f_valid_i && (!l_valid_i || r_last_l)) begin
            r_state  <= StGrantF;
            r_last_l <= 1'b0;
            r_cnt    <= 16'd0;
          end else if (l_valid_i) begin
            r_state  <= StGrantL;
            r_last_l <= 1'b1;
            r_cnt    <= 16'd0;
          end
        end
        StGrantF, StGrantL: begin
          if (w_done) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    grant_o     = 2'b00;
    mem_valid_o = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    mem_wstrb_o = 4'd0;
    f_ready_o   = 1'b0;
    l_ready_o   = 1'b0;
    err_o       = 1'b0;
    case (r_state)
      StGrantF: begin
        grant_o     = 2'b01;
        mem_valid_o = 1'b1;
        mem_addr_o  = f_addr_i;
        f_ready_o   = w_done;
        err_o       = w_timeout;
      end
      StGrantL: begin
        grant_o     = 2'b10;
        mem_valid_o = 1'b1;
        mem_addr_o  = l_addr_i;
        mem_wdata_o = l_wdata_i;
        mem_wstrb_o = l_wstrb_i;
        l_ready_o   = w_done;
        err_o       = w_timeout;
      end
      default: ;
    endcase
  end

  assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with a 4-cycle watchdog, one with it disabled,
// both driven by the same stimulus; completions are checked against a queue of expected results.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        f_valid_i;
  logic [31:0] f_addr_i;
  logic        l_valid_i;
  logic [31:0] l_addr_i;
  logic [31:0] l_wdata_i;
  logic [3:0]  l_wstrb_i;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  logic        a_f_ready, a_l_ready, a_err, a_mem_valid;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata;
  logic [1:0]  a_grant;
  logic [3:0]  a_mem_wstrb;
  logic        b_f_ready, b_l_ready, b_err, b_mem_valid;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata;
  logic [1:0]  b_grant;
  logic [3:0]  b_mem_wstrb;

  // Selected-instance view used by the checking tasks.
  logic        dut_sel;
  logic        s_f_ready, s_l_ready, s_err, s_mem_valid;
  logic [31:0] s_rdata, s_mem_addr, s_mem_wdata;
  logic [1:0]  s_grant;
  logic [3:0]  s_mem_wstrb;

  always_comb begin
    s_f_ready   = dut_sel ? b_f_ready   : a_f_ready;
    s_l_ready   = dut_sel ? b_l_ready   : a_l_ready;
    s_err       = dut_sel ? b_err       : a_err;
    s_mem_valid = dut_sel ? b_mem_valid : a_mem_valid;
    s_rdata     = dut_sel ? b_rdata     : a_rdata;
    s_mem_addr  = dut_sel ? b_mem_addr  : a_mem_addr;
    s_mem_wdata = dut_sel ? b_mem_wdata : a_mem_wdata;
    s_grant     = dut_sel ? b_grant     : a_grant;
    s_mem_wstrb = dut_sel ? b_mem_wstrb : a_mem_wstrb;
  end

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .f_valid_i   (f_valid_i),
    .f_addr_i    (f_addr_i),
    .f_ready_o   (a_f_ready),
    .l_valid_i   (l_valid_i),
    .l_addr_i    (l_addr_i),
    .l_wdata_i   (l_wdata_i),
    .l_wstrb_i   (l_wstrb_i),
    .l_ready_o   (a_l_ready),
    .rdata_o     (a_rdata),
    .err_o       (a_err),
    .grant_o     (a_grant),
    .mem_addr_o  (a_mem_addr),
    .mem_wdata_o (a_mem_wdata),
    .mem_wstrb_o (a_mem_wstrb),
    .mem_valid_o (a_mem_valid),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i)
  );

  mem_port_arbiter #(.TIMEOUT_CYCLES(0)) u_dut_nowd (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .f_valid_i   (f_valid_i),
    .f_addr_i    (f_addr_i),
    .f_ready_o   (b_f_ready),
    .l_valid_i   (l_valid_i),
    .l_addr_i    (l_addr_i),
    .l_wdata_i   (l_wdata_i),
    .l_wstrb_i   (l_wstrb_i),
    .l_ready_o   (b_l_ready),
    .rdata_o     (b_rdata),
    .err_o       (b_err),
    .grant_o     (b_grant),
    .mem_addr_o  (b_mem_addr),
    .mem_wdata_o (b_mem_wdata),
    .mem_wstrb_o (b_mem_wstrb),
    .mem_valid_o (b_mem_valid),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        is_l;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    #1 rst_i = 1'b1;
    #2 rst_i = 1'b0;
  endtask

  // Samples one IDLE cycle, then returns just after the following rising edge.
  task automatic idle_chk(input string tag);
    @(negedge clk_i);
    chk({tag, "_grant"}, 32'(s_grant), 32'd0);
    chk({tag, "_valid"}, 32'(s_mem_valid), 32'd0);
    chk({tag, "_ready"}, 32'({s_f_ready, s_l_ready}), 32'd0);
    step();
  endtask

  // Called just after the edge that enters the grant. Memory answers in grant cycle 'lat'
  // (-1 = never); the completion must appear in grant cycle 'exp_cyc'.
  task automatic serve(input logic sel, input int lat, input int exp_cyc, input logic is_l,
                       input logic exp_err, input logic [31:0] rd, input logic [31:0] e_addr,
                       input logic [31:0] e_wdata, input logic [3:0] e_wstrb, input int budget);
    exp_t e;
    exp_t got;
    bit   seen;
    dut_sel = sel;
    e.is_l  = is_l;
    e.rdata = rd;
    e.err   = exp_err;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      mem_ready_i = (i == lat);
      mem_rdata_i = rd;
      @(negedge clk_i);
      if (i == 0) begin
        chk("grant", 32'(s_grant), is_l ? 32'd2 : 32'd1);
        chk("mem_valid", 32'(s_mem_valid), 32'd1);
        chk("mem_addr", s_mem_addr, e_addr);
        chk("mem_wdata", s_mem_wdata, e_wdata);
        chk("mem_wstrb", 32'(s_mem_wstrb), 32'(e_wstrb));
      end
      if (s_f_ready || s_l_ready) begin
        seen = 1'b1;
        chk("done_cycle", 32'(i), 32'(exp_cyc));
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          got = sb.pop_front();
          chk("ready_port", 32'({s_f_ready, s_l_ready}), 32'({~got.is_l, got.is_l}));
          chk("err", 32'(s_err), 32'(got.err));
          chk("rdata", s_rdata, got.rdata);
        end
        break;
      end
      step();
    end
    if (!seen) begin
      chk("done_seen", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    f_valid_i   = 1'b0;
    f_addr_i    = '0;
    l_valid_i   = 1'b0;
    l_addr_i    = '0;
    l_wdata_i   = '0;
    l_wstrb_i   = '0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'hA5A5_0001;
    dut_sel     = 1'b0;

    // Reset state.
    #2;
    chk("rst_grant", 32'(a_grant), 32'd0);
    chk("rst_valid", 32'(a_mem_valid), 32'd0);
    chk("rst_addr", a_mem_addr, 32'd0);
    chk("rst_ready", 32'({a_f_ready, a_l_ready, a_err}), 32'd0);
    chk("rst_rdata", a_rdata, 32'hA5A5_0001);
    step();
    rst_i = 1'b0;

    // Single fetch, memory ready in the first grant cycle.
    f_valid_i = 1'b1;
    f_addr_i  = 32'h100;
    @(negedge clk_i);
    chk("pre_grant", 32'(a_grant), 32'd0);
    step();
    serve(1'b0, 0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h100, 32'd0, 4'd0, 8);
    step();
    mem_ready_i = 1'b0;
    f_valid_i   = 1'b0;
    idle_chk("t1_after");

    // Tie after reset: F first, then the store from L, then the next tie goes to F.
    do_reset();
    f_valid_i = 1'b1;
    f_addr_i  = 32'h300;
    l_valid_i = 1'b1;
    l_addr_i  = 32'h200;
    l_wdata_i = 32'h1234_5678;
    l_wstrb_i = 4'hF;
    step();
    serve(1'b0, 1, 1, 1'b0, 1'b0, 32'h1111_1111, 32'h300, 32'd0, 4'd0, 8);
    step();
    mem_ready_i = 1'b0;
    f_valid_i   = 1'b0;
    idle_chk("t2_idle1");
    serve(1'b0, 0, 0, 1'b1, 1'b0, 32'hCAFE_0002, 32'h200, 32'h1234_5678, 4'hF, 8);
    step();
    mem_ready_i = 1'b0;
    f_valid_i   = 1'b1;
    f_addr_i    = 32'h304;
    idle_chk("t2_idle2");
    serve(1'b0, 0, 0, 1'b0, 1'b0, 32'h3333_0003, 32'h304, 32'd0, 4'd0, 8);
    step();
    mem_ready_i = 1'b0;
    f_valid_i   = 1'b0;
    l_valid_i   = 1'b0;
    idle_chk("t2_idle3");

    // L held while F issues three requests: grants alternate F, L, F, L, F, L.
    do_reset();
    f_valid_i = 1'b1;
    f_addr_i  = 32'h500;
    l_valid_i = 1'b1;
    l_addr_i  = 32'h208;
    l_wstrb_i = 4'h0;
    step();
    for (int i = 0; i < 3; i++) begin
      serve(1'b0, 0, 0, 1'b0, 1'b0, 32'hF0 + 32'(i), 32'h500 + 32'(4 * i), 32'd0, 4'd0, 8);
      step();
      mem_ready_i = 1'b0;
      f_addr_i    = 32'h500 + 32'(4 * (i + 1));
      if (i == 2) f_valid_i = 1'b0;
      idle_chk("t3_idle_f");
      serve(1'b0, 0, 0, 1'b1, 1'b0, 32'h10 + 32'(i), 32'h208, 32'h1234_5678, 4'h0, 8);
      step();
      mem_ready_i = 1'b0;
      if (i == 2) l_valid_i = 1'b0;
      idle_chk("t3_idle_l");
    end

    // Watchdog of 4: abort in the 4th grant cycle; ready in that same cycle wins.
    l_valid_i = 1'b1;
    l_addr_i  = 32'h600;
    l_wdata_i = 32'hAB;
    l_wstrb_i = 4'h3;
    step();
    serve(1'b0, -1, 3, 1'b1, 1'b1, 32'h55, 32'h600, 32'hAB, 4'h3, 10);
    step();
    idle_chk("t4_idle");
    serve(1'b0, 3, 3, 1'b1, 1'b0, 32'h66, 32'h600, 32'hAB, 4'h3, 10);
    step();
    mem_ready_i = 1'b0;
    l_valid_i   = 1'b0;
    idle_chk("t4_idle2");

    // Async reset mid-grant drops the request at once and restores F priority.
    do_reset();
    l_valid_i = 1'b1;
    l_addr_i  = 32'h700;
    step();
    @(negedge clk_i);
    chk("t5_granted", 32'(a_grant), 32'd2);
    #1 rst_i = 1'b1;
    #1;
    chk("t5_valid_drop", 32'(a_mem_valid), 32'd0);
    chk("t5_grant_drop", 32'(a_grant), 32'd0);
    chk("t5_no_ready", 32'({a_f_ready, a_l_ready, a_err}), 32'd0);
    f_valid_i = 1'b1;
    f_addr_i  = 32'h800;
    step();
    chk("t5_held", 32'({a_mem_valid, a_l_ready}), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
    serve(1'b0, 0, 0, 1'b0, 1'b0, 32'h77, 32'h800, 32'd0, 4'd0, 8);
    step();
    mem_ready_i = 1'b0;
    f_valid_i   = 1'b0;
    l_valid_i   = 1'b0;
    idle_chk("t5_idle");

    // Watchdog disabled: a 200-cycle stall completes normally.
    do_reset();
    f_valid_i = 1'b1;
    f_addr_i  = 32'h900;
    step();
    serve(1'b1, 200, 200, 1'b0, 1'b0, 32'h99, 32'h900, 32'd0, 4'd0, 260);
    step();
    mem_ready_i = 1'b0;
    f_valid_i   = 1'b0;
    idle_chk("t6_idle");

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
